// File: rtl/wb_scoreboard_arbiter_pkg.sv
// rtl/wb_scoreboard_arbiter_pkg.sv - shared widths, grant encodings and FIFO entry type for the writeback arbiter
package wb_scoreboard_arbiter_pkg;

  localparam int REG_WIDTH = 32;
  localparam int IDX_WIDTH = 4;
  localparam int NUM_REGS  = 16;
  localparam int CNT_WIDTH = 3;
  localparam int PTR_WIDTH = 2;

  typedef logic [IDX_WIDTH-1:0] regIdx_t;
  typedef logic [REG_WIDTH-1:0] regData_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_ALU  = 2'd3
  } wbSrc_t;

  typedef struct packed {
    regIdx_t  idx;
    regData_t data;
  } wbEntry_t;

endpackage

// File: rtl/wb_scoreboard_arbiter_if.sv
// rtl/wb_scoreboard_arbiter_if.sv - issue, writeback-source and register-file write signals of the arbiter
interface wb_scoreboard_arbiter_if;
  import wb_scoreboard_arbiter_pkg::*;

  logic                I_LOCK;
  logic                I_IssueValid;
  logic                I_IssueWritesReg;
  regIdx_t             I_IssueDestIdx;
  logic                I_Src1Used;
  logic                I_Src2Used;
  regIdx_t             I_Src1Idx;
  regIdx_t             I_Src2Idx;
  logic                O_DepStall;
  logic                I_AluWbValid;
  regIdx_t             I_AluWbIdx;
  regData_t            I_AluWbData;
  logic                I_MemWbValid;
  regIdx_t             I_MemWbIdx;
  regData_t            I_MemWbData;
  logic                O_WriteBackEnable;
  regIdx_t             O_WriteBackRegIdx;
  regData_t            O_WriteBackData;
  logic [NUM_REGS-1:0] O_BusyVec;

  modport master (
    output I_LOCK, I_IssueValid, I_IssueWritesReg, I_IssueDestIdx,
    output I_Src1Used, I_Src2Used, I_Src1Idx, I_Src2Idx,
    output I_AluWbValid, I_AluWbIdx, I_AluWbData,
    output I_MemWbValid, I_MemWbIdx, I_MemWbData,
    input  O_DepStall, O_WriteBackEnable, O_WriteBackRegIdx, O_WriteBackData, O_BusyVec
  );

  modport slave (
    input  I_LOCK, I_IssueValid, I_IssueWritesReg, I_IssueDestIdx,
    input  I_Src1Used, I_Src2Used, I_Src1Idx, I_Src2Idx,
    input  I_AluWbValid, I_AluWbIdx, I_AluWbData,
    input  I_MemWbValid, I_MemWbIdx, I_MemWbData,
    output O_DepStall, O_WriteBackEnable, O_WriteBackRegIdx, O_WriteBackData, O_BusyVec
  );

endinterface

// File: rtl/wb_alu_buffer.sv
// rtl/wb_alu_buffer.sv - small FIFO holding ALU results that lost writeback arbitration
module wb_alu_buffer
  import wb_scoreboard_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 pushValid,
  input  wbEntry_t             pushEntry,
  input  logic                 popReady,
  output wbEntry_t             headEntry,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  wbEntry_t             mem [DEPTH];
  logic [PTR_WIDTH-1:0] wrPtr;
  logic [PTR_WIDTH-1:0] rdPtr;
  logic                 doPush;
  logic                 doPop;

  assign full      = (count == CNT_WIDTH'(DEPTH));
  assign empty     = (count == '0);
  assign doPop     = popReady && !empty;
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign doPush    = pushValid && (!full || doPop);
  assign headEntry = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= (wrPtr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= (rdPtr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
      end
      if (doPush && !doPop && !full) begin
        count <= count + 1'b1;
      end else if (doPop && !doPush && !empty) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_scoreboard_arbiter.sv
// rtl/wb_scoreboard_arbiter.sv - register-file write arbiter (MEM > FIFO > ALU) with busy scoreboard and dependency stall
// Optional macro WB_SCOREBOARD_BYPASS_EN: registers written on this edge are not considered busy for stall.
module wb_scoreboard_arbiter
  import wb_scoreboard_arbiter_pkg::*;
#(
  parameter int ALU_BUF_DEPTH = 2,
  parameter int STALL_THRESH  = 1
) (
  input logic                    I_CLOCK,
  input logic                    I_RESET_N,
  wb_scoreboard_arbiter_if.slave wb
);

  wbSrc_t               grant;
  wbEntry_t             grantEntry;
  wbEntry_t             fifoHead;
  logic [CNT_WIDTH-1:0] fifoCount;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 fifoPush;
  logic                 fifoPop;
  logic [NUM_REGS-1:0]  busyVec;
  logic [NUM_REGS-1:0]  busyView;
  logic [NUM_REGS-1:0]  clearMask;
  logic [NUM_REGS-1:0]  setMask;
  logic                 depStall;
  logic                 wbEnableQ;
  regIdx_t              wbIdxQ;
  regData_t             wbDataQ;

  always_comb begin
    grant      = SRC_NONE;
    grantEntry = '{idx: wb.I_AluWbIdx, data: wb.I_AluWbData};
    if (wb.I_LOCK) begin
      if (wb.I_MemWbValid) begin
        grant      = SRC_MEM;
        grantEntry = '{idx: wb.I_MemWbIdx, data: wb.I_MemWbData};
      end else if (!fifoEmpty) begin
        grant      = SRC_FIFO;
        grantEntry = fifoHead;
      end else if (wb.I_AluWbValid) begin
        grant      = SRC_ALU;
      end
    end
  end

  assign fifoPush = wb.I_LOCK && wb.I_AluWbValid && (grant != SRC_ALU);
  assign fifoPop  = (grant == SRC_FIFO);

  wb_alu_buffer #(.DEPTH(ALU_BUF_DEPTH)) aluBuffer (
    .clk       (I_CLOCK),
    .rstN      (I_RESET_N),
    .pushValid (fifoPush),
    .pushEntry ('{idx: wb.I_AluWbIdx, data: wb.I_AluWbData}),
    .popReady  (fifoPop),
    .headEntry (fifoHead),
    .count     (fifoCount),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  always_comb begin
    clearMask = '0;
    if (grant != SRC_NONE) begin
      clearMask[grantEntry.idx] = 1'b1;
    end
  end

`ifdef WB_SCOREBOARD_BYPASS_EN
  assign busyView = busyVec & ~clearMask;
`else
  assign busyView = busyVec;
`endif

  assign depStall = wb.I_LOCK && wb.I_IssueValid &&
                    ((wb.I_Src1Used && busyView[wb.I_Src1Idx]) ||
                     (wb.I_Src2Used && busyView[wb.I_Src2Idx]) ||
                     (wb.I_IssueWritesReg && busyView[wb.I_IssueDestIdx]) ||
                     (32'(fifoCount) >= STALL_THRESH));

  always_comb begin
    setMask = '0;
    if (wb.I_LOCK && wb.I_IssueValid && wb.I_IssueWritesReg && !depStall) begin
      setMask[wb.I_IssueDestIdx] = 1'b1;
    end
  end

  // Set is OR'd in after clear so a same-index collision leaves the register busy.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      busyVec   <= '0;
      wbEnableQ <= 1'b0;
      wbIdxQ    <= '0;
      wbDataQ   <= '0;
    end else if (!wb.I_LOCK) begin
      wbEnableQ <= 1'b0;
    end else begin
      busyVec   <= (busyVec & ~clearMask) | setMask;
      wbEnableQ <= (grant != SRC_NONE);
      if (grant != SRC_NONE) begin
        wbIdxQ  <= grantEntry.idx;
        wbDataQ <= grantEntry.data;
      end
    end
  end

  assign wb.O_DepStall        = depStall;
  assign wb.O_WriteBackEnable = wbEnableQ && wb.I_LOCK;
  assign wb.O_WriteBackRegIdx = wbIdxQ;
  assign wb.O_WriteBackData   = wbDataQ;
  assign wb.O_BusyVec         = busyVec;

  aluBufferOverflow: assert property (@(posedge I_CLOCK) disable iff (!I_RESET_N)
    !(fifoPush && fifoFull && !fifoPop));

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// tb/tb_wb_scoreboard_arbiter.sv - directed self-checking bench for wb_scoreboard_arbiter
module tb_wb_scoreboard_arbiter;

  logic clk;
  logic rstN;
  int   passed;
  int   total;

  wb_scoreboard_arbiter_if bus ();

  wb_scoreboard_arbiter #(.ALU_BUF_DEPTH(2), .STALL_THRESH(1)) dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rstN),
    .wb        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearIn();
    bus.I_IssueValid     = 1'b0;
    bus.I_IssueWritesReg = 1'b0;
    bus.I_IssueDestIdx   = '0;
    bus.I_Src1Used       = 1'b0;
    bus.I_Src2Used       = 1'b0;
    bus.I_Src1Idx        = '0;
    bus.I_Src2Idx        = '0;
    bus.I_AluWbValid     = 1'b0;
    bus.I_AluWbIdx       = '0;
    bus.I_AluWbData      = '0;
    bus.I_MemWbValid     = 1'b0;
    bus.I_MemWbIdx       = '0;
    bus.I_MemWbData      = '0;
  endtask

  task automatic issueDest(input logic [3:0] dest);
    bus.I_IssueValid     = 1'b1;
    bus.I_IssueWritesReg = 1'b1;
    bus.I_IssueDestIdx   = dest;
  endtask

  task automatic alu(input logic [3:0] idx, input logic [31:0] data);
    bus.I_AluWbValid = 1'b1;
    bus.I_AluWbIdx   = idx;
    bus.I_AluWbData  = data;
  endtask

  task automatic mem(input logic [3:0] idx, input logic [31:0] data);
    bus.I_MemWbValid = 1'b1;
    bus.I_MemWbIdx   = idx;
    bus.I_MemWbData  = data;
  endtask

  task automatic expectWb(input string tag, input logic [3:0] idx, input logic [31:0] data);
    chk({tag, "_en"}, 32'(bus.O_WriteBackEnable), 32'd1);
    chk({tag, "_idx"}, 32'(bus.O_WriteBackRegIdx), 32'(idx));
    chk({tag, "_data"}, bus.O_WriteBackData, data);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rstN     = 1'b0;
    bus.I_LOCK = 1'b1;
    clearIn();

    // Reset state
    tick();
    tick();
    chk("rst_en", 32'(bus.O_WriteBackEnable), 32'd0);
    chk("rst_idx", 32'(bus.O_WriteBackRegIdx), 32'd0);
    chk("rst_data", bus.O_WriteBackData, 32'd0);
    chk("rst_busy", 32'(bus.O_BusyVec), 32'd0);
    chk("rst_stall", 32'(bus.O_DepStall), 32'd0);
    rstN = 1'b1;
    tick();

    // Issue to R3, then ALU writeback to R3
    issueDest(4'd3);
    settle();
    chk("t1_stall", 32'(bus.O_DepStall), 32'd0);
    tick();
    clearIn();
    chk("t1_busy_set", 32'(bus.O_BusyVec), 32'h0008);
    alu(4'd3, 32'h1234);
    tick();
    expectWb("t1_wb", 4'd3, 32'h1234);
    chk("t1_busy_clr", 32'(bus.O_BusyVec), 32'h0000);
    clearIn();
    tick();
    chk("t1_idle_en", 32'(bus.O_WriteBackEnable), 32'd0);
    chk("t1_idle_idx", 32'(bus.O_WriteBackRegIdx), 32'd3);
    chk("t1_idle_data", bus.O_WriteBackData, 32'h1234);

    // RAW on R5
    issueDest(4'd5);
    tick();
    clearIn();
    chk("t2_busy", 32'(bus.O_BusyVec), 32'h0020);
    bus.I_IssueValid = 1'b1;
    bus.I_Src1Used   = 1'b1;
    bus.I_Src1Idx    = 4'd5;
    settle();
    chk("t2_stall_a", 32'(bus.O_DepStall), 32'd1);
    tick();
    chk("t2_stall_b", 32'(bus.O_DepStall), 32'd1);
    alu(4'd5, 32'h5555_0005);
    settle();
`ifdef WB_SCOREBOARD_BYPASS_EN
    chk("t2_stall_grant", 32'(bus.O_DepStall), 32'd0);
`else
    chk("t2_stall_grant", 32'(bus.O_DepStall), 32'd1);
`endif
    tick();
    expectWb("t2_wb", 4'd5, 32'h5555_0005);
    chk("t2_busy_clr", 32'(bus.O_BusyVec), 32'h0000);
    chk("t2_stall_after", 32'(bus.O_DepStall), 32'd0);
    clearIn();

    // MEM/ALU collision: MEM first, ALU from FIFO next
    bus.I_IssueValid = 1'b1;
    mem(4'd1, 32'hAAAA);
    alu(4'd2, 32'h5555);
    settle();
    chk("t3_stall_pre", 32'(bus.O_DepStall), 32'd0);
    tick();
    expectWb("t3_wb1", 4'd1, 32'hAAAA);
    bus.I_MemWbValid = 1'b0;
    bus.I_AluWbValid = 1'b0;
    settle();
    chk("t3_stall_cnt1", 32'(bus.O_DepStall), 32'd1);
    tick();
    expectWb("t3_wb2", 4'd2, 32'h5555);
    chk("t3_stall_cnt0", 32'(bus.O_DepStall), 32'd0);
    clearIn();
    tick();
    chk("t3_idle_en", 32'(bus.O_WriteBackEnable), 32'd0);

    // FIFO stress: MEM x3, ALU on first two cycles
    bus.I_IssueValid = 1'b1;
    mem(4'd8, 32'h81);
    alu(4'd9, 32'h91);
    settle();
    chk("t4_stall_pre", 32'(bus.O_DepStall), 32'd0);
    tick();
    expectWb("t4_wb1", 4'd8, 32'h81);
    chk("t4_stall1", 32'(bus.O_DepStall), 32'd1);
    mem(4'd10, 32'h82);
    alu(4'd11, 32'h92);
    tick();
    expectWb("t4_wb2", 4'd10, 32'h82);
    chk("t4_stall2", 32'(bus.O_DepStall), 32'd1);
    mem(4'd12, 32'h83);
    bus.I_AluWbValid = 1'b0;
    tick();
    expectWb("t4_wb3", 4'd12, 32'h83);
    chk("t4_stall3", 32'(bus.O_DepStall), 32'd1);
    bus.I_MemWbValid = 1'b0;
    tick();
    expectWb("t4_wb4", 4'd9, 32'h91);
    chk("t4_stall4", 32'(bus.O_DepStall), 32'd1);
    tick();
    expectWb("t4_wb5", 4'd11, 32'h92);
    chk("t4_stall5", 32'(bus.O_DepStall), 32'd0);
    clearIn();
    tick();
    chk("t4_idle_en", 32'(bus.O_WriteBackEnable), 32'd0);

    // LOCK low for four cycles with R7 busy and ALU pending
    issueDest(4'd7);
    settle();
    chk("t5_issue_stall", 32'(bus.O_DepStall), 32'd0);
    tick();
    clearIn();
    chk("t5_busy", 32'(bus.O_BusyVec), 32'h0080);
    bus.I_LOCK       = 1'b0;
    alu(4'd7, 32'h77);
    bus.I_IssueValid = 1'b1;
    bus.I_Src1Used   = 1'b1;
    bus.I_Src1Idx    = 4'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_lock_en%0d", i), 32'(bus.O_WriteBackEnable), 32'd0);
      chk($sformatf("t5_lock_busy%0d", i), 32'(bus.O_BusyVec), 32'h0080);
      chk($sformatf("t5_lock_stall%0d", i), 32'(bus.O_DepStall), 32'd0);
    end
    bus.I_LOCK = 1'b1;
    settle();
    chk("t5_resume_stall", 32'(bus.O_DepStall), 32'd1);
    tick();
    expectWb("t5_wb", 4'd7, 32'h77);
    chk("t5_busy_clr", 32'(bus.O_BusyVec), 32'h0000);
    clearIn();
    tick();
    chk("t5_idle_en", 32'(bus.O_WriteBackEnable), 32'd0);

    // Async reset mid-cycle with busy=0xF0 and FIFO holding two entries
    for (int r = 4; r < 8; r++) begin
      issueDest(4'(r));
      tick();
    end
    clearIn();
    chk("t6_busy", 32'(bus.O_BusyVec), 32'h00F0);
    mem(4'd0, 32'h1);
    alu(4'd1, 32'h2);
    tick();
    mem(4'd2, 32'h3);
    alu(4'd3, 32'h4);
    tick();
    clearIn();
    expectWb("t6_pre_wb", 4'd2, 32'h3);
    bus.I_IssueValid = 1'b1;
    settle();
    chk("t6_stall_cnt2", 32'(bus.O_DepStall), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    chk("t6_rst_en", 32'(bus.O_WriteBackEnable), 32'd0);
    chk("t6_rst_idx", 32'(bus.O_WriteBackRegIdx), 32'd0);
    chk("t6_rst_data", bus.O_WriteBackData, 32'd0);
    chk("t6_rst_busy", 32'(bus.O_BusyVec), 32'd0);
    chk("t6_rst_stall", 32'(bus.O_DepStall), 32'd0);
    clearIn();
    tick();
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_post_en%0d", i), 32'(bus.O_WriteBackEnable), 32'd0);
      chk($sformatf("t6_post_busy%0d", i), 32'(bus.O_BusyVec), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
